ifetch: RTL and testbench

Instruction fetch stage: owns the fetch PC, issues requests on the instruction bus, and buffers returned instruction words in a 2-entry FIFO. Presents one `{pc, inst}` pair per cycle to the IF/ID pipeline register. Handles branch redirect from EX by flushing the buffer and discarding in-flight responses. Holds its output when the pipeline stalls.

---
 rtl/ifetch.sv | 138 +++++++++++++
 tb/tb_ifetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the fetch PC, keeps up to two bus requests in flight in order,
// and buffers returned words as {pc, inst} pairs in a 2-entry FIFO presented to IF/ID.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_addr_i,
  input  logic        stall_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 2;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW-1:0]   acount;
  logic [CW-1:0]   waive;

  logic [XLEN-1:0] fifo_pc   [2];
  logic [XLEN-1:0] fifo_inst [2];
  logic [XLEN-1:0] addr_q    [2];

  logic            pop;
  logic            grant;
  logic            rsp;
  logic            push;
  logic            apop;
  logic [CW:0]     credit_use;
  logic [CW-1:0]   outstanding_nxt;

  // Low address bits of a redirect target are forced to word alignment.
  logic unused_branch_lsb;
  assign unused_branch_lsb = ^ex_branch_addr_i[1:0];

  assign inst_valid_o = (count != '0);
  assign pc_o         = inst_valid_o ? fifo_pc[0]   : '0;
  assign inst_o       = inst_valid_o ? fifo_inst[0] : INST_NOP;
  assign ibus_addr_o  = fetch_pc;

  // Credit check: in-flight requests plus buffered words (after this cycle's pop) must leave room.
  always_comb begin
    pop             = inst_valid_o && !stall_i && !ex_branch_flag_i;
    credit_use      = (CW+1)'(outstanding) + (CW+1)'(count) - (CW+1)'(pop);
    ibus_req_o      = !rst && !ex_branch_flag_i && (credit_use < (CW+1)'(2));
    grant           = ibus_req_o && ibus_gnt_i;
    rsp             = ibus_rvalid_i && (outstanding != '0);
    push            = rsp && (discard == '0) && !ex_branch_flag_i;
    apop            = rsp && (discard == '0) && !ex_branch_flag_i;
    outstanding_nxt = outstanding + CW'(grant) - CW'(rsp);
  end

  // Control state; a redirect drops every request still in flight after this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= {RESET_PC[XLEN-1:2], 2'b00};
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      acount      <= '0;
      waive       <= CW'(2);
    end else begin
      if (waive != '0) begin
        waive <= waive - CW'(1);
      end
      outstanding <= outstanding_nxt;
      if (ex_branch_flag_i) begin
        fetch_pc <= {ex_branch_addr_i[XLEN-1:2], 2'b00};
        discard  <= outstanding_nxt;
        count    <= '0;
        acount   <= '0;
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (rsp && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
        count  <= count + CW'(push) - CW'(pop);
        acount <= acount + CW'(grant) - CW'(apop);
      end
    end
  end

  // Instruction buffer storage; head is always entry 0.
  always_ff @(posedge clk) begin
    if (push) begin
      if (pop && (count == CW'(2))) begin
        fifo_pc[0]   <= fifo_pc[1];
        fifo_inst[0] <= fifo_inst[1];
        fifo_pc[1]   <= addr_q[0];
        fifo_inst[1] <= ibus_rdata_i;
      end else if (pop) begin
        fifo_pc[0]   <= addr_q[0];
        fifo_inst[0] <= ibus_rdata_i;
      end else begin
        fifo_pc[count[0]]   <= addr_q[0];
        fifo_inst[count[0]] <= ibus_rdata_i;
      end
    end else if (pop) begin
      fifo_pc[0]   <= fifo_pc[1];
      fifo_inst[0] <= fifo_inst[1];
    end
  end

  // Granted addresses, paired in order with their responses.
  always_ff @(posedge clk) begin
    if (grant) begin
      if (apop && (acount == CW'(2))) begin
        addr_q[0] <= addr_q[1];
        addr_q[1] <= fetch_pc;
      end else if (apop) begin
        addr_q[0] <= fetch_pc;
      end else begin
        addr_q[acount[0]] <= fetch_pc;
      end
    end else if (apop) begin
      addr_q[0] <= addr_q[1];
    end
  end

  rvalid_has_outstanding: assert property (
    @(posedge clk) disable iff (rst || (waive != '0))
    !(ibus_rvalid_i && (outstanding == '0)));

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: queue-based reference model plus an in-order bus with per-request latency.
module tb_ifetch;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hC0DE_0000;

  logic        clk;
  logic        rst;
  logic        ex_branch_flag_i;
  logic [31:0] ex_branch_addr_i;
  logic        stall_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  ifetch #(.RESET_PC(32'h0000_0000), .INST_NOP(INST_NOP)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_branch_flag_i (ex_branch_flag_i),
    .ex_branch_addr_i (ex_branch_addr_i),
    .stall_i          (stall_i),
    .ibus_req_o       (ibus_req_o),
    .ibus_addr_o      (ibus_addr_o),
    .ibus_gnt_i       (ibus_gnt_i),
    .ibus_rvalid_i    (ibus_rvalid_i),
    .ibus_rdata_i     (ibus_rdata_i),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .inst_valid_o     (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } bus_t;
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  bus_t bus_q[$];
  req_t m_out[$];
  ent_t m_fifo[$];
  logic [31:0] m_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance model and bus.
  task automatic step(input logic r, input logic f, input logic [31:0] ba,
                      input logic st, input logic g, input int lat);
    logic rv;
    logic pop;
    logic exp_req;
    int   used;
    ent_t e;
    req_t q;
    @(negedge clk);
    rst = r;
    ex_branch_flag_i = f;
    ex_branch_addr_i = ba;
    stall_i = st;
    ibus_gnt_i = g;
    rv = (bus_q.size() > 0) && (bus_q[0].due <= cyc);
    ibus_rvalid_i = rv;
    ibus_rdata_i = rv ? mem(bus_q[0].addr) : $urandom;
    #1;
    pop = (m_fifo.size() > 0) && !st && !f;
    used = m_out.size() + m_fifo.size() - (pop ? 1 : 0);
    exp_req = !r && !f && (used < 2);
    s_req = ibus_req_o; s_addr = ibus_addr_o;
    s_pc = pc_o; s_inst = inst_o; s_valid = inst_valid_o;
    chk("req", 32'(s_req), 32'(exp_req));
    if (exp_req) chk("addr", s_addr, m_pc);
    if (m_fifo.size() > 0) begin
      chk("valid", 32'(s_valid), 32'd1);
      chk("pc", s_pc, m_fifo[0].pc);
      chk("inst", s_inst, m_fifo[0].inst);
    end else begin
      chk("valid", 32'(s_valid), 32'd0);
      chk("pc", s_pc, 32'h0);
      chk("inst", s_inst, INST_NOP);
    end
    @(posedge clk);
    if (rv) void'(bus_q.pop_front());
    if (s_req && g) bus_q.push_back('{addr: s_addr, due: cyc + lat});
    if (r) begin
      m_pc = 32'h0;
      m_out.delete();
      m_fifo.delete();
      bus_q.delete();
    end else begin
      if (rv && m_out.size() > 0) begin
        q = m_out.pop_front();
        if (!q.stale && !f) begin
          e.pc = q.addr;
          e.inst = ibus_rdata_i;
          m_fifo.push_back(e);
        end
      end
      if (f) begin
        m_fifo.delete();
        foreach (m_out[i]) m_out[i].stale = 1'b1;
        m_pc = {ba[31:2], 2'b00};
      end else begin
        if (pop) void'(m_fifo.pop_front());
        if (exp_req && g) begin
          m_out.push_back('{addr: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] held;
    bit seen;
    rst = 1'b1; ex_branch_flag_i = 1'b0; ex_branch_addr_i = 32'h0; stall_i = 1'b0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
    m_pc = 32'h0;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);

    // Zero-wait streaming from the reset PC
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
      chk("zw_req", 32'(s_req), 32'd1);
      chk("zw_addr", s_addr, 32'(4 * k));
      if (k >= 2) begin
        chk("zw_valid", 32'(s_valid), 32'd1);
        chk("zw_pc", s_pc, 32'(4 * (k - 2)));
        chk("zw_inst", s_inst, 32'(4 * (k - 2)) ^ KEY);
      end else begin
        chk("zw_valid_empty", 32'(s_valid), 32'd0);
      end
    end

    // Grant withheld for three cycles at address 8
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, (k < 2 || k > 4), 1);
      if (k >= 2 && k <= 5) chk("gw_addr_hold", s_addr, 32'h8);
      if (k == 3) chk("gw_pc4", s_pc, 32'h4);
      if (k == 4) begin
        chk("gw_empty_valid", 32'(s_valid), 32'd0);
        chk("gw_empty_nop", s_inst, INST_NOP);
      end
      if (k == 7) chk("gw_resume_pc", s_pc, 32'h8);
    end

    // Four-cycle stall: head holds, requests stop, no loss after release
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    held = s_pc;
    chk("st_req_drop", 32'(s_req), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      chk("st_pc_hold", s_pc, held);
      chk("st_req_off", 32'(s_req), 32'd0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    chk("st_release_pc", s_pc, held);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    chk("st_next_pc", s_pc, held + 32'd4);

    // Redirect to 0x106 with slow responses in flight
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    step(1'b0, 1'b1, 32'h106, 1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    chk("br_req", 32'(s_req), 32'd1);
    chk("br_addr", s_addr, 32'h104);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
      if (s_valid && !seen) begin
        seen = 1'b1;
        chk("br_first_pc", s_pc, 32'h104);
      end
    end
    if (!seen) chk("br_first_valid_timeout", 32'd0, 32'd1);

    // Redirect coincident with a response and a stall
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    chk("brs_flushed", 32'(s_valid), 32'd0);
    chk("brs_addr", s_addr, 32'h200);

    // Reset while the buffer is full
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("rst_req_low", 32'(s_req), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_inst", s_inst, INST_NOP);
    chk("rst_req", 32'(s_req), 32'd1);
    chk("rst_addr", s_addr, 32'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(199) == 0), ($urandom_range(99) < 6), $urandom,
           ($urandom_range(99) < 30), ($urandom_range(99) < 70), int'($urandom_range(3, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
